// File: rtl/axi4_lite_xintf_regbank_if.sv
// AXI4-Lite slave channel bundle for axi4_lite_xintf_regbank.
interface axi4_lite_xintf_regbank_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_xintf_regbank.sv
// AXI4-Lite register bank shared between PS (control), PL (status) and the DSP XINTF bus.
// Define XINTF_ATOMIC_EN for atomic 32-bit transfers via a read shadow and write pending half.
module axi4_lite_xintf_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 9,
  parameter int N_CTRL             = 32,
  parameter int N_STAT             = 32,
  parameter int N_DSP              = 32,
  parameter int XINTF_WR_BASE      = 256
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  axi4_lite_xintf_regbank_if.slave s_axi,
  input  logic [8:0]              i_xintf_addr,
  input  logic [15:0]             i_xintf_d_to_z_data,
  input  logic                    i_dsp_we,
  input  logic                    i_dsp_rd,
  output logic [15:0]             o_xintf_z_to_d_data,
  input  logic [32*N_STAT-1:0]    i_stat_data,
  output logic [32*N_CTRL-1:0]    o_ctrl_data,
  output logic [N_CTRL-1:0]       o_ctrl_wr_stb,
  output logic [32*N_DSP-1:0]     o_dsp_data,
  output logic [N_DSP-1:0]        o_dsp_wr_stb
);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] WR_BASE     = 32'(XINTF_WR_BASE);
  localparam logic [31:0] WR_SPAN     = 32'(2 * N_DSP);

  logic [32*N_CTRL-1:0] ctrl_q, ctrl_d;
  logic [32*N_STAT-1:0] stat_q;
  logic [32*N_DSP-1:0]  dsp_q, dsp_d;
  logic [N_CTRL-1:0]    ctrl_stb_q, ctrl_stb_d;
  logic [N_DSP-1:0]     dsp_stb_q, dsp_stb_d;
  logic                 awready_q, awready_d, bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
  logic                 arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 we_q, we_hist_q, rd_q, rd_hist_q;
  logic [8:0]           xaddr_q;
  logic [15:0]          xdata_q;

  // Returns {hit, word} for a flat word index; DSP words are only visible to AXI.
  function automatic logic [32:0] pickWord(input logic [31:0] idx,
                                           input logic [32*N_CTRL-1:0] c,
                                           input logic [32*N_STAT-1:0] s,
                                           input logic [32*N_DSP-1:0] d,
                                           input logic inclDsp);
    logic [32:0] r;
    r = '0;
    for (int k = 0; k < N_CTRL; k++)
      if (idx == 32'(k)) r = {1'b1, c[32*k +: 32]};
    for (int k = 0; k < N_STAT; k++)
      if (idx == 32'(N_CTRL + k)) r = {1'b1, s[32*k +: 32]};
    for (int k = 0; k < N_DSP; k++)
      if (inclDsp && idx == 32'(N_CTRL + N_STAT + k)) r = {1'b1, d[32*k +: 32]};
    return r;
  endfunction

  logic [31:0] aw_idx, ar_idx;
  logic [32:0] ar_pick, xr_pick;
  logic        wr_fire, rd_fire, we_fall, rd_fall, xw_hit;
  logic [31:0] xw_off, xw_idx;
  logic        unused_axi;

  assign aw_idx  = 32'(s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ar_idx  = 32'(s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ar_pick = pickWord(ar_idx, ctrl_q, stat_q, dsp_q, 1'b1);
  assign wr_fire = awready_q && s_axi.AWVALID && s_axi.WVALID;
  assign rd_fire = arready_q && s_axi.ARVALID;
  assign unused_axi = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  assign we_fall = we_hist_q && !we_q;
  assign rd_fall = rd_hist_q && !rd_q;
  assign xw_off  = 32'(xaddr_q) - WR_BASE;
  assign xw_hit  = (32'(xaddr_q) >= WR_BASE) && (xw_off < WR_SPAN);
  assign xw_idx  = xw_off >> 1;
  assign xr_pick = pickWord(32'(i_xintf_addr[8:1]), ctrl_q, stat_q, dsp_q, 1'b0);

  // Write channel: one AW/W accept at a time, blocked while a response is outstanding.
  always_comb begin
    awready_d  = s_axi.AWVALID && s_axi.WVALID && !awready_q && !bvalid_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ctrl_d     = ctrl_q;
    ctrl_stb_d = '0;
    if (bvalid_q && s_axi.BREADY) bvalid_d = 1'b0;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      for (int k = 0; k < N_CTRL; k++) begin
        if (aw_idx == 32'(k)) begin
          for (int b = 0; b < 4; b++)
            if (s_axi.WSTRB[b]) ctrl_d[32*k+8*b +: 8] = s_axi.WDATA[8*b +: 8];
          ctrl_stb_d[k] = 1'b1;
          bresp_d       = RESP_OKAY;
        end
      end
    end
  end

  always_comb begin
    arready_d = s_axi.ARVALID && !arready_q && !rvalid_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (rvalid_q && s_axi.RREADY) rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_pick[31:0];
      rresp_d  = ar_pick[32] ? RESP_OKAY : RESP_SLVERR;
    end
  end

`ifdef XINTF_ATOMIC_EN
  logic [15:0] rd_shadow_q, rd_shadow_d, wr_pending_q, wr_pending_d;
  logic [32:0] cap_pick;
  logic        unused_hi;

  assign cap_pick  = pickWord(32'(xaddr_q[8:1]), ctrl_q, stat_q, dsp_q, 1'b0);
  assign unused_hi = ^xr_pick[31:16];

  // Low half is parked until the high half arrives; a low-half read freezes the high half.
  always_comb begin
    dsp_d        = dsp_q;
    dsp_stb_d    = '0;
    wr_pending_d = wr_pending_q;
    rd_shadow_d  = rd_shadow_q;
    if (we_fall && xw_hit) begin
      if (!xw_off[0]) begin
        wr_pending_d = xdata_q;
      end else begin
        wr_pending_d = '0;
        for (int k = 0; k < N_DSP; k++) begin
          if (xw_idx == 32'(k)) begin
            dsp_d[32*k +: 32] = {xdata_q, wr_pending_q};
            dsp_stb_d[k]      = 1'b1;
          end
        end
      end
    end
    if (rd_fall && !xaddr_q[0]) rd_shadow_d = cap_pick[32] ? cap_pick[31:16] : 16'h0000;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_shadow_q  <= '0;
      wr_pending_q <= '0;
    end else begin
      rd_shadow_q  <= rd_shadow_d;
      wr_pending_q <= wr_pending_d;
    end
  end

  assign o_xintf_z_to_d_data = !xr_pick[32] ? 16'h0000 :
                               (i_xintf_addr[0] ? rd_shadow_q : xr_pick[15:0]);
`else
  logic unused_rd;
  assign unused_rd = rd_fall;

  always_comb begin
    dsp_d     = dsp_q;
    dsp_stb_d = '0;
    if (we_fall && xw_hit) begin
      for (int k = 0; k < N_DSP; k++) begin
        if (xw_idx == 32'(k)) begin
          if (xw_off[0]) dsp_d[32*k+16 +: 16] = xdata_q;
          else           dsp_d[32*k +: 16]    = xdata_q;
          dsp_stb_d[k] = 1'b1;
        end
      end
    end
  end

  assign o_xintf_z_to_d_data = !xr_pick[32] ? 16'h0000 :
                               (i_xintf_addr[0] ? xr_pick[31:16] : xr_pick[15:0]);
`endif

  // Two-stage strobe history gives the falling-edge detect; address/data are aligned with it.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ctrl_q     <= '0;
      stat_q     <= '0;
      dsp_q      <= '0;
      ctrl_stb_q <= '0;
      dsp_stb_q  <= '0;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      we_hist_q  <= 1'b0;
      rd_q       <= 1'b0;
      rd_hist_q  <= 1'b0;
      xaddr_q    <= '0;
      xdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      stat_q     <= i_stat_data;
      dsp_q      <= dsp_d;
      ctrl_stb_q <= ctrl_stb_d;
      dsp_stb_q  <= dsp_stb_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      we_q       <= i_dsp_we;
      we_hist_q  <= we_q;
      rd_q       <= i_dsp_rd;
      rd_hist_q  <= rd_q;
      xaddr_q    <= i_xintf_addr;
      xdata_q    <= i_xintf_d_to_z_data;
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = awready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RDATA   = rdata_q;
  assign o_ctrl_data   = ctrl_q;
  assign o_ctrl_wr_stb = ctrl_stb_q;
  assign o_dsp_data    = dsp_q;
  assign o_dsp_wr_stb  = dsp_stb_q;
endmodule
